spi_reg_responder: RTL
======================

// Module: spi_reg_responder
// PURPOSE
//  System-clock-domain SPI peripheral that terminates controller frames at the PWM register bank.
//  Oversamples SCK/CS/COPI on clk, decodes a 16-bit command, updates the 6x10-bit register file,
//  then returns a 16-bit response in the same CS-low window (after the controller's PAUSE).
//  Feeds mode_manual/en_pwm/duty/freq into the multi-phase PWM core; CIPO goes to the CIPO mux.
// PARAMETERS
//  LENGTH_RECIEVED  16      command bits shifted in (controller->peripheral)
//  LENGTH_SEND      16      response bits shifted out (peripheral->controller)
//  DATA_W           10      register width
//  NUM_REGS         6       implemented registers (addr 0..5)
//  ADDR_W           3       address field width
//  SYNC_STAGES      2       synchronizer depth on SCK, CS, COPI (>=2)
//  DEVICE_ID        10'h2A5 value of read-only ID register
//  FREQ_RST         10'd500 reset value of FREQ_SWITCH
// PORTS
//  clk          in   1       system clock; must be >= 8x SCK frequency
//  rst          in   1       asynchronous active-low reset
//  SCK          in   1       SPI clock (mode 0: idle low, sample rising, shift falling)
//  CS           in   1       chip select, active low
//  COPI         in   1       controller-out data, MSB first
//  CIPO         out  1       peripheral-out data, MSB first; 0 when CS high
//  status_in    in   DATA_W  live status, captured on read of addr 4
//  mode_manual  out  1       CTRL[1]
//  en_pwm       out  1       CTRL[0]
//  duty_high    out  DATA_W  reg 1
//  duty_low     out  DATA_W  reg 2
//  freq_switch  out  DATA_W  reg 3
//  frame_done   out  1       1-clk pulse at end of valid TX phase
//  frame_err    out  1       1-clk pulse in DECODE on bad addr / RO write / reserved bits set
// BEHAVIOUR
//  Reset (rst=0, async): all regs 0 except FREQ_SWITCH=FREQ_RST; state IDLE; CIPO=0; pulses 0.
//  Sync: SCK/CS/COPI through SYNC_STAGES flops; rise/fall of SCK from last two synced samples.
//  Command: [15]=1 write/0 read, [14:12]=addr, [11:10] reserved (must be 0), [9:0]=wdata.
//  Map: 0 CTRL{..,mode_manual,en_pwm} RW; 1 DUTY_HIGH RW; 2 DUTY_LOW RW; 3 FREQ_SWITCH RW;
//       4 STATUS RO (status_in); 5 ID RO (DEVICE_ID). CTRL bits [9:2] read 0, writes ignored.
//  Response: [15:13]=addr echo, [12]=err, [11:10]=0, [9:0]=reg value after any write; err -> data 0.
//  FSM: IDLE -(CS low)-> RX; RX shifts COPI on each sync SCK rise, bit counter 0..15;
//       16th rise -> DECODE (1 clk: commit write, set frame_err, load TX shifter, CIPO=bit15);
//       DECODE -> TX; TX: on each SCK fall shift next bit; after 16th fall -> DONE;
//       DONE: pulse frame_done, hold CIPO=0, wait CS high -> IDLE.
//  Latency: register outputs change 1 clk after DECODE (SYNC_STAGES+2 clk after 16th SCK rise).
//  PAUSE gap (SCK idle) in TX/DONE is tolerated; no counting during idle SCK.
//  CS high in any state: abort to IDLE next clk; uncommitted write discarded; no frame_done.
//  Extra SCK edges in DONE ignored. CS low at reset release: wait for CS high before IDLE->RX.
//  Invalid addr (6,7), write to 4/5, or reserved bits !=0: no reg change, err=1, frame_err pulse.
//  Read of STATUS samples status_in in DECODE clk only.
// STRUCTURE
//  Package spi_reg_pkg: state enum (IDLE,RX,DECODE,TX,DONE), address localparams ADDR_CTRL..ADDR_ID,
//  command field positions, FREQ_RST/DEVICE_ID defaults; shared with PWM core and bench.
//  One sub-module: spi_edge_sync (N-stage synchronizer + SCK rise/fall detect).
//  Top holds FSM, bit counter, RX/TX shifters, register file.
// TESTING
//  1 Write 0x8000|0x1F4 to addr 1 -> duty_high=0x1F4 after DECODE; response 0x21F4 ({3'd1,0,00,1F4}).
//  2 Read addr 5 (0x5000) -> response 0xA2A5; no register changes; frame_done pulses once.
//  3 Write addr 4 (0xC155) -> frame_err pulse, STATUS unchanged, response 0x9000.
//  4 CS raised after 9 RX bits of write addr 3 -> freq_switch stays 500, no frame_done; next frame OK.
//  5 Async rst low mid-TX -> all outputs reset immediately, CIPO=0; new frame after release works.
//  6 Back-to-back frames at clk=8xSCK with PAUSE=10: write CTRL=0x3 then read -> en_pwm=mode_manual=1,
//    response 0x0003.

Source files
------------

// File: rtl/spi_reg_pkg.sv
// Shared definitions for the SPI register responder, the PWM core and the bench.
package spi_reg_pkg;

  localparam int unsigned LENGTH_RECIEVED = 16;
  localparam int unsigned LENGTH_SEND     = 16;
  localparam int unsigned DATA_W          = 10;
  localparam int unsigned NUM_REGS        = 6;
  localparam int unsigned ADDR_W          = 3;
  localparam int unsigned SYNC_STAGES     = 2;
  localparam int unsigned CNT_W           = $clog2(LENGTH_RECIEVED);

  localparam logic [DATA_W-1:0] DEVICE_ID = 10'h2A5;
  localparam logic [DATA_W-1:0] FREQ_RST  = 10'd500;

  localparam logic [ADDR_W-1:0] ADDR_CTRL      = 3'd0;
  localparam logic [ADDR_W-1:0] ADDR_DUTY_HIGH = 3'd1;
  localparam logic [ADDR_W-1:0] ADDR_DUTY_LOW  = 3'd2;
  localparam logic [ADDR_W-1:0] ADDR_FREQ      = 3'd3;
  localparam logic [ADDR_W-1:0] ADDR_STATUS    = 3'd4;
  localparam logic [ADDR_W-1:0] ADDR_ID        = 3'd5;

  typedef enum logic [2:0] {IDLE, RX, DECODE, TX, DONE} state_e;

  // Command word as shifted in, MSB first
  typedef struct packed {
    logic              wr;
    logic [ADDR_W-1:0] addr;
    logic [1:0]        rsvd;
    logic [DATA_W-1:0] wdata;
  } cmd_t;

  // Response word as shifted out, MSB first
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic              err;
    logic [1:0]        rsvd;
    logic [DATA_W-1:0] data;
  } resp_t;

endpackage

// File: rtl/spi_reg_responder_if.sv
// SPI bus between controller and the register responder.
interface spi_reg_responder_if;
  logic SCK;
  logic CS;
  logic COPI;
  logic CIPO;

  modport master (output SCK, output CS, output COPI, input CIPO);
  modport slave  (input SCK, input CS, input COPI, output CIPO);
endinterface

// File: rtl/spi_edge_sync.sv
// Synchronizes SCK/CS/COPI into clk and flags SCK rising/falling edges.
module spi_edge_sync
  import spi_reg_pkg::*;
#(
  parameter int unsigned STAGES = SYNC_STAGES
) (
  input  logic clk,
  input  logic rst,
  input  logic sck_raw,
  input  logic cs_raw,
  input  logic copi_raw,
  output logic sck_rise_c,
  output logic sck_fall_c,
  output logic cs_sync,
  output logic copi_sync
);

  logic [STAGES-1:0] sck_ff;
  logic [STAGES-1:0] cs_ff;
  logic [STAGES-1:0] copi_ff;
  logic              sck_prev;

  // Synchronizer chains; CS resets low so a held-low CS is never mistaken for idle
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sck_ff   <= '0;
      cs_ff    <= '0;
      copi_ff  <= '0;
      sck_prev <= 1'b0;
    end else begin
      sck_ff   <= {sck_ff[STAGES-2:0], sck_raw};
      cs_ff    <= {cs_ff[STAGES-2:0], cs_raw};
      copi_ff  <= {copi_ff[STAGES-2:0], copi_raw};
      sck_prev <= sck_ff[STAGES-1];
    end
  end

  assign cs_sync    = cs_ff[STAGES-1];
  assign copi_sync  = copi_ff[STAGES-1];
  assign sck_rise_c = sck_ff[STAGES-1] & ~sck_prev;
  assign sck_fall_c = ~sck_ff[STAGES-1] & sck_prev;

endmodule

// File: rtl/spi_reg_responder.sv
// SPI peripheral: receives a 16-bit command, updates the PWM register bank, returns a response.
module spi_reg_responder
  import spi_reg_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  spi_reg_responder_if.slave  spi,
  input  logic [DATA_W-1:0]   status_in,
  output logic                mode_manual,
  output logic                en_pwm,
  output logic [DATA_W-1:0]   duty_high,
  output logic [DATA_W-1:0]   duty_low,
  output logic [DATA_W-1:0]   freq_switch,
  output logic                frame_done,
  output logic                frame_err
);

  localparam logic [CNT_W-1:0] RX_LAST = CNT_W'(LENGTH_RECIEVED - 1);
  localparam logic [CNT_W-1:0] TX_LAST = CNT_W'(LENGTH_SEND - 1);

  logic                       sck_rise_c;
  logic                       sck_fall_c;
  logic                       cs_sync;
  logic                       copi_sync;
  state_e                     state;
  logic [CNT_W-1:0]           bit_cnt;
  logic [LENGTH_RECIEVED-1:0] rx_shift;
  logic [LENGTH_SEND-1:0]     tx_shift;
  logic                       seen_rise;
  logic                       cs_armed;
  cmd_t                       cmd;
  resp_t                      resp;
  logic                       cmd_err;
  logic [DATA_W-1:0]          rd_val;

  spi_edge_sync #(.STAGES(SYNC_STAGES)) u_sync (
    .clk        (clk),
    .rst        (rst),
    .sck_raw    (spi.SCK),
    .cs_raw     (spi.CS),
    .copi_raw   (spi.COPI),
    .sck_rise_c (sck_rise_c),
    .sck_fall_c (sck_fall_c),
    .cs_sync    (cs_sync),
    .copi_sync  (copi_sync)
  );

  assign cmd      = cmd_t'(rx_shift);
  assign spi.CIPO = tx_shift[LENGTH_SEND-1];

  // Command decode: error check and the value returned after any write
  always_comb begin
    rd_val  = '0;
    cmd_err = (cmd.addr >= ADDR_W'(NUM_REGS))
            || (cmd.wr && (cmd.addr == ADDR_STATUS || cmd.addr == ADDR_ID))
            || (cmd.rsvd != 2'b00);
    case (cmd.addr)
      ADDR_CTRL:      rd_val = cmd.wr ? DATA_W'(cmd.wdata[1:0]) : DATA_W'({mode_manual, en_pwm});
      ADDR_DUTY_HIGH: rd_val = cmd.wr ? cmd.wdata : duty_high;
      ADDR_DUTY_LOW:  rd_val = cmd.wr ? cmd.wdata : duty_low;
      ADDR_FREQ:      rd_val = cmd.wr ? cmd.wdata : freq_switch;
      ADDR_STATUS:    rd_val = status_in;
      ADDR_ID:        rd_val = DEVICE_ID;
      default:        rd_val = '0;
    endcase
    resp.addr = cmd.addr;
    resp.err  = cmd_err;
    resp.rsvd = 2'b00;
    resp.data = cmd_err ? '0 : rd_val;
  end

  // Frame FSM, shifters and register file; CS high aborts from any state
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      bit_cnt     <= '0;
      rx_shift    <= '0;
      tx_shift    <= '0;
      seen_rise   <= 1'b0;
      cs_armed    <= 1'b0;
      frame_done  <= 1'b0;
      frame_err   <= 1'b0;
      mode_manual <= 1'b0;
      en_pwm      <= 1'b0;
      duty_high   <= '0;
      duty_low    <= '0;
      freq_switch <= FREQ_RST;
    end else begin
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
      if (cs_sync) cs_armed <= 1'b1;
      if (cs_sync && state != IDLE) begin
        state    <= IDLE;
        tx_shift <= '0;
      end else begin
        case (state)
          IDLE: begin
            tx_shift <= '0;
            if (!cs_sync && cs_armed) begin
              state   <= RX;
              bit_cnt <= '0;
            end
          end
          RX: begin
            if (sck_rise_c) begin
              rx_shift <= {rx_shift[LENGTH_RECIEVED-2:0], copi_sync};
              bit_cnt  <= bit_cnt + CNT_W'(1);
              if (bit_cnt == RX_LAST) state <= DECODE;
            end
          end
          DECODE: begin
            if (cmd.wr && !cmd_err) begin
              case (cmd.addr)
                ADDR_CTRL:      {mode_manual, en_pwm} <= cmd.wdata[1:0];
                ADDR_DUTY_HIGH: duty_high   <= cmd.wdata;
                ADDR_DUTY_LOW:  duty_low    <= cmd.wdata;
                ADDR_FREQ:      freq_switch <= cmd.wdata;
                default:        ;
              endcase
            end
            frame_err <= cmd_err;
            tx_shift  <= resp;
            bit_cnt   <= '0;
            seen_rise <= 1'b0;
            state     <= TX;
          end
          TX: begin
            // Only a fall that follows a TX rise advances; the trailing RX fall is skipped
            if (sck_rise_c) begin
              seen_rise <= 1'b1;
            end else if (sck_fall_c && seen_rise) begin
              seen_rise <= 1'b0;
              bit_cnt   <= bit_cnt + CNT_W'(1);
              tx_shift  <= {tx_shift[LENGTH_SEND-2:0], 1'b0};
              if (bit_cnt == TX_LAST) begin
                state      <= DONE;
                frame_done <= 1'b1;
              end
            end
          end
          DONE: tx_shift <= '0;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
